// File: rtl/dm_lsu_rmw.sv
// Load/store initiator for the 1 KiB byte-addressed data memory; sub-word stores are read-modify-write.
// Optional build macro DM_LSU_ALIGN_CHECK_EN: misaligned requests complete with err and no memory access.
//
// state   | meaning
// IDLE    | waiting for req; mem_addr holds its last value
// RD      | memory word being read for a load or for a sub-word merge
// WR      | mem_we high; memory captures mem_wdata at the end of this cycle
// DONE    | done pulse (err with it for a rejected request), then back to IDLE
module dm_lsu_rmw #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;

  logic          is_byte, is_half, is_word;
  logic          misalign;
  logic [1:0]    lane_acc;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [DW-1:0] load_val;
  logic [DW-1:0] merged;

  assign is_byte = (size == 2'b00);
  assign is_half = (size == 2'b01);
  assign is_word = size[1];

`ifdef DM_LSU_ALIGN_CHECK_EN
  assign misalign = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
  assign lane_acc = addr[1:0];
`else
  // Without the check, ignored low address bits snap the access to its natural lane.
  assign misalign = 1'b0;
  assign lane_acc = is_byte ? addr[1:0] : (is_half ? {addr[1], 1'b0} : 2'b00);
`endif

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        2'd3:    merged[31:24] = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    wr_d        = wr_q;
    size_d      = size_q;
    sext_d      = sext_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          lane_d  = lane_acc;
          wr_d    = wr;
          size_d  = size;
          sext_d  = sext;
          wdata_d = wdata[15:0];
          err_d   = misalign;
          if (misalign) begin
            state_d = S_DONE;
          end else begin
            mem_addr_d = {addr[AW-1:2], 2'b00};
            if (wr && is_word) begin
              mem_wdata_d = wdata;
              mem_we_d    = 1'b1;
              state_d     = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD: begin
        if (wr_q) begin
          mem_wdata_d = merged;
          mem_we_d    = 1'b1;
          state_d     = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        state_d = S_DONE;
      end
      default: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lane_q      <= 2'b00;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      sext_q      <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      sext_q      <= sext_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done & err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_dm_lsu_rmw.sv
// Bench for dm_lsu_rmw: vector table of single accesses against a behavioural word memory,
// plus hand sequences for misalignment, reset during a write and held-request back-to-back.
module tb_dm_lsu_rmw;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sext;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  dm_lsu_rmw #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sext;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pre;
    logic [31:0] exp_word;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_we_at;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request and counts negedges after the accepting posedge until done.
  task automatic run(input logic w, input logic [1:0] s, input logic sx, input logic [9:0] a,
                     input logic [31:0] wd, output int lat, output int we_cnt,
                     output int we_at, output logic err_s);
    lat = -1; we_cnt = 0; we_at = 0; err_s = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = w; size = s; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (mem_we) begin
        we_cnt++;
        we_at = n;
      end
      if (done) begin
        lat = n;
        err_s = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int lat, we_cnt, we_at;
    logic err_s;
    int pulses;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; sext = 1'b0; addr = '0; wdata = '0;

    //             wr    size   sext  addr    wdata         pre           exp_word      exp_rdata     lat we_at
    vecs[0]  = '{1'b0, 2'b10, 1'b0, 10'h010, 32'h0,        32'h11223344, 32'h11223344, 32'h11223344, 2, 0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 10'h013, 32'h0,        32'h84223344, 32'h84223344, 32'hFFFFFF84, 2, 0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 10'h013, 32'h0,        32'h84223344, 32'h84223344, 32'h00000084, 2, 0};
    vecs[3]  = '{1'b1, 2'b00, 1'b0, 10'h011, 32'h123456AB, 32'h11223344, 32'h1122AB44, 32'h00000084, 3, 2};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 10'h012, 32'h5555BEEF, 32'h11223344, 32'hBEEF3344, 32'h00000084, 3, 2};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 10'h012, 32'h0,        32'hBEEF3344, 32'hBEEF3344, 32'hFFFFBEEF, 2, 0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 10'h010, 32'h0,        32'hBEEF3344, 32'hBEEF3344, 32'h00003344, 2, 0};
    vecs[7]  = '{1'b0, 2'b00, 1'b1, 10'h010, 32'h0,        32'h11223344, 32'h11223344, 32'h00000044, 2, 0};
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 10'h020, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000044, 2, 1};
    vecs[9]  = '{1'b0, 2'b10, 1'b1, 10'h020, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2, 0};
    vecs[10] = '{1'b1, 2'b00, 1'b0, 10'h023, 32'hFFFFFF7F, 32'hDEADBEEF, 32'h7FADBEEF, 32'hDEADBEEF, 3, 2};
    vecs[11] = '{1'b0, 2'b00, 1'b0, 10'h021, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h000000BE, 2, 0};
    vecs[12] = '{1'b0, 2'b11, 1'b1, 10'h030, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2, 0};
    vecs[13] = '{1'b0, 2'b01, 1'b1, 10'h3FE, 32'h0,        32'h80017FFF, 32'h80017FFF, 32'hFFFF8001, 2, 0};

    #1;
    chk("reset busy", {31'b0, busy}, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset err", {31'b0, err}, 32'h0);
    chk("reset mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    chk("reset mem_addr", {22'b0, mem_addr}, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      mem[vecs[i].addr[9:2]] = vecs[i].pre;
      run(vecs[i].wr, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
          lat, we_cnt, we_at, err_s);
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d err", i), {31'b0, err_s}, 32'h0);
      chk($sformatf("v%0d busy_in_done", i), {31'b0, busy}, 32'h1);
      chk($sformatf("v%0d we_count", i), we_cnt, (vecs[i].exp_we_at != 0) ? 1 : 0);
      chk($sformatf("v%0d we_cycle", i), we_at, vecs[i].exp_we_at);
      chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d mem_word", i), mem[vecs[i].addr[9:2]], vecs[i].exp_word);
      @(negedge clk);
      chk($sformatf("v%0d done_one_cycle", i), {31'b0, done}, 32'h0);
      chk($sformatf("v%0d idle_after", i), {31'b0, busy}, 32'h0);
    end

    // Misaligned word load and halfword store.
    mem[10'h010 >> 2] = 32'h11223344;
    run(1'b0, 2'b10, 1'b0, 10'h011, 32'h0, lat, we_cnt, we_at, err_s);
`ifdef DM_LSU_ALIGN_CHECK_EN
    chk("mis_load latency", lat, 1);
    chk("mis_load err", {31'b0, err_s}, 32'h1);
    chk("mis_load rdata_kept", rdata, 32'hFFFF8001);
`else
    chk("mis_load latency", lat, 2);
    chk("mis_load err", {31'b0, err_s}, 32'h0);
    chk("mis_load rdata", rdata, 32'h11223344);
`endif
    chk("mis_load we_count", we_cnt, 0);
    @(negedge clk);

    run(1'b1, 2'b01, 1'b0, 10'h013, 32'h0000BEEF, lat, we_cnt, we_at, err_s);
`ifdef DM_LSU_ALIGN_CHECK_EN
    chk("mis_store latency", lat, 1);
    chk("mis_store err", {31'b0, err_s}, 32'h1);
    chk("mis_store we_count", we_cnt, 0);
    chk("mis_store mem_word", mem[10'h010 >> 2], 32'h11223344);
`else
    chk("mis_store latency", lat, 3);
    chk("mis_store err", {31'b0, err_s}, 32'h0);
    chk("mis_store we_count", we_cnt, 1);
    chk("mis_store mem_word", mem[10'h010 >> 2], 32'hBEEF3344);
`endif
    @(negedge clk);

    // Reset asserted mid-cycle while the word store is in WR.
    mem[10'h040 >> 2] = 32'h0BADF00D;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'b10; sext = 1'b0; addr = 10'h040; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("rstwr mem_we_before", {31'b0, mem_we}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rstwr mem_we_drop", {31'b0, mem_we}, 32'h0);
    chk("rstwr busy_drop", {31'b0, busy}, 32'h0);
    chk("rstwr done_low", {31'b0, done}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("rstwr done_pulses", pulses, 0);
    chk("rstwr mem_untouched", mem[10'h040 >> 2], 32'h0BADF00D);
    run(1'b0, 2'b10, 1'b0, 10'h040, 32'h0, lat, we_cnt, we_at, err_s);
    chk("rstwr next_latency", lat, 2);
    chk("rstwr next_rdata", rdata, 32'h0BADF00D);
    @(negedge clk);

    // Request held high: ignored in DONE, accepted again after one IDLE cycle.
    mem[10'h010 >> 2] = 32'h11223344;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; sext = 1'b0; addr = 10'h010; wdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b busy_rd", {31'b0, busy}, 32'h1);
    @(negedge clk);
    chk("b2b done", {31'b0, done}, 32'h1);
    @(negedge clk);
    chk("b2b idle_gap", {31'b0, busy}, 32'h0);
    @(negedge clk);
    chk("b2b reaccept", {31'b0, busy}, 32'h1);
    req = 1'b0;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) begin
        pulses = 1;
        break;
      end
      @(negedge clk);
    end
    chk("b2b second_done", pulses, 1);
    chk("b2b rdata", rdata, 32'h11223344);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
